uart_tx_scheduler: RTL and testbench

//  Round-robin scheduler that shares one byte-level UART transmitter between NCH motor channels.

---
 rtl/uart_tx_scheduler.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte-level UART transmitter between NCH channels.
// Define UART_TX_SCHED_CSUM_EN to append a checksum byte (header XOR data) to each packet.

module uart_tx_scheduler #(
    parameter int unsigned NCH        = 4,
    parameter logic [3:0]  HDR_TAG    = 4'hA,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH-1:0]   REQ,
    input  logic [8*NCH-1:0] REQ_DATA,
    output logic [NCH-1:0]   GNT,
    output logic [7:0]       TX_DATA,
    output logic             TX_START,
    input  logic             TX_BUSY,
    input  logic             TX_DONE,
    output logic             ACTIVE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HDR_W,
        S_DAT,
        S_DAT_W,
`ifdef UART_TX_SCHED_CSUM_EN
        S_CSM,
        S_CSM_W,
`endif
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [7:0]     txd_q, txd_d;
    logic [7:0]     byte_q, byte_d;
    logic           txs_q, txs_d;
    logic           act_q, act_d;
    logic [3:0]     rr_q, rr_d;
    logic [3:0]     ch_q, ch_d;
    logic [15:0]    gap_q, gap_d;

    logic [2*NCH-1:0] req_rot;
    logic [8*NCH-1:0] data_rot;
    logic [3:0]       pick_off;
    logic [4:0]       pick_sum;
    logic [3:0]       pick_idx;
    logic             pick_found;
    logic [7:0]       pick_byte;
    logic [7:0]       hdr_byte;
    logic [3:0]       rr_next;
    logic             done_ok;
    logic             pkt_done;

    // Requests rotated so bit 0 is the round-robin pointer; first set bit is the offset.
    always_comb begin
        req_rot    = {REQ, REQ} >> rr_q;
        pick_found = 1'b0;
        pick_off   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!pick_found && req_rot[0]) begin
                pick_found = 1'b1;
                pick_off   = 4'(k);
            end
            req_rot = req_rot >> 1;
        end
    end

    assign pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    assign pick_idx = (pick_sum >= 5'(NCH)) ? 4'(pick_sum - 5'(NCH)) : pick_sum[3:0];

    always_comb begin
        data_rot  = REQ_DATA;
        pick_byte = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (4'(k) == pick_idx) pick_byte = data_rot[7:0];
            data_rot = data_rot >> 8;
        end
    end

    assign hdr_byte = {HDR_TAG, ch_q};
    assign rr_next  = (ch_q == 4'(NCH - 1)) ? '0 : ch_q + 4'd1;
    // A TX_DONE coinciding with our own TX_START belongs to no byte of ours.
    assign done_ok  = TX_DONE && !txs_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        txd_d    = txd_q;
        txs_d    = 1'b0;
        act_d    = act_q;
        rr_d     = rr_q;
        gap_d    = gap_q;
        ch_d     = ch_q;
        byte_d   = byte_q;
        pkt_done = 1'b0;
        case (state_q)
            S_IDLE: if (gap_q == '0 && pick_found) begin
                gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
                ch_d    = pick_idx;
                byte_d  = pick_byte;
                act_d   = 1'b1;
                state_d = S_HDR;
            end
            S_HDR: if (!TX_BUSY) begin
                txs_d   = 1'b1;
                txd_d   = hdr_byte;
                state_d = S_HDR_W;
            end
            S_HDR_W: if (done_ok) state_d = S_DAT;
            S_DAT: if (!TX_BUSY) begin
                txs_d   = 1'b1;
                txd_d   = byte_q;
                state_d = S_DAT_W;
            end
            S_DAT_W: if (done_ok) begin
`ifdef UART_TX_SCHED_CSUM_EN
                state_d = S_CSM;
`else
                pkt_done = 1'b1;
`endif
            end
`ifdef UART_TX_SCHED_CSUM_EN
            S_CSM: if (!TX_BUSY) begin
                txs_d   = 1'b1;
                txd_d   = hdr_byte ^ byte_q;
                state_d = S_CSM_W;
            end
            S_CSM_W: if (done_ok) pkt_done = 1'b1;
`endif
            S_GAP: begin
                gap_d = gap_q - 16'd1;
                if (gap_q <= 16'd1) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pkt_done) begin
            act_d   = 1'b0;
            rr_d    = rr_next;
            gap_d   = 16'(GAP_CYCLES);
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            txd_q   <= 8'hFF;
            txs_q   <= 1'b0;
            act_q   <= 1'b0;
            rr_q    <= '0;
            gap_q   <= '0;
            ch_q    <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            txd_q   <= txd_d;
            txs_q   <= txs_d;
            act_q   <= act_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            ch_q    <= ch_d;
            byte_q  <= byte_d;
        end
    end

    assign GNT      = gnt_q;
    assign TX_DATA  = txd_q;
    assign TX_START = txs_q;
    assign ACTIVE   = act_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: behavioural transmitter, vector table, corner sequences, random traffic.
module tb_uart_tx_scheduler;
    localparam int NCH  = 4;
    localparam int GAP  = 16;
    localparam int XCYC = 6;
`ifdef UART_TX_SCHED_CSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [NCH-1:0]   REQ;
    logic [8*NCH-1:0] REQ_DATA;
    logic [NCH-1:0]   GNT;
    logic [7:0]       TX_DATA;
    logic             TX_START;
    logic             TX_BUSY;
    logic             TX_DONE;
    logic             ACTIVE;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   cnt = 0;
    int   start_cnt = 0;
    int   last_done_cyc = -1000;
    logic have_done = 1'b0;
    logic done_m = 1'b0;
    logic done_inj = 1'b0;
    logic busy_force = 1'b0;
    logic early_arm = 1'b0;
    logic act_prev = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] tx_log[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_ch;
        logic [7:0]  exp_dat;
    } vec_t;
    vec_t vt[6];

    uart_tx_scheduler #(.NCH(NCH), .HDR_TAG(4'hA), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
        .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_BUSY(TX_BUSY),
        .TX_DONE(TX_DONE), .ACTIVE(ACTIVE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign TX_BUSY = (cnt != 0) || busy_force;
    assign TX_DONE = done_m || done_inj;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Transmitter model: busy XCYC cycles per byte, then a one-cycle TX_DONE.
    always @(negedge CLK) begin
        done_m = 1'b0;
        if (!RST) begin
            cnt = 0;
        end else if (TX_START) begin
            chk("start_not_busy", {31'd0, TX_BUSY}, 32'd0);
            chk("start_after_done", {31'd0, (cyc - last_done_cyc) >= 2}, 32'd1);
            tx_log.push_back(TX_DATA);
            cur_byte = TX_DATA;
            start_cnt++;
            cnt = XCYC;
            if (early_arm) begin
                done_m    = 1'b1;
                early_arm = 1'b0;
            end
        end else if (cnt != 0) begin
            chk("tx_data_stable", {24'd0, TX_DATA}, {24'd0, cur_byte});
            cnt--;
            if (cnt == 0) begin
                done_m        = 1'b1;
                last_done_cyc = cyc;
                have_done     = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (GNT != '0) begin
                chk("gnt_onehot", $countones(GNT), 32'd1);
                chk("gnt_while_active", {31'd0, act_prev}, 32'd0);
            end
            act_prev = ACTIVE;
        end else begin
            act_prev = 1'b0;
        end
    end

    task automatic wait_grant(output int ch);
        ch = -1;
        for (int i = 0; i < 400 && ch < 0; i++) begin
            @(negedge CLK);
            if (GNT != '0)
                for (int b = 0; b < NCH; b++) if (GNT[b] && ch < 0) ch = b;
        end
        if (ch < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=none required=grant");
        end else if (have_done) begin
            chk("gap_len", {31'd0, (cyc - last_done_cyc) >= GAP + 1}, 32'd1);
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while (ACTIVE && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (ACTIVE) begin
            checks++;
            failures++;
            $display("FAIL packet_timeout actual=active required=idle");
        end
    endtask

    task automatic check_pkt(input string nm, input int ch, input logic [7:0] dat);
        logic [7:0] eb[3];
        eb[0] = {4'hA, 4'(ch)};
        eb[1] = dat;
        eb[2] = eb[0] ^ dat;
        chk({nm, "_nbytes"}, tx_log.size(), NB);
        for (int i = 0; i < NB; i++)
            if (tx_log.size() > 0) chk($sformatf("%s_byte%0d", nm, i), {24'd0, tx_log.pop_front()}, {24'd0, eb[i]});
        tx_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ch, s0, n, bad, exp_ch, rr, k;
        logic [3:0] pend;
        logic [7:0] pdat[NCH];
        logic [7:0] gbyte;

        vt[0] = '{4'b0100, 32'h115C3344, 2, 8'h5C};
        vt[1] = '{4'b0011, 32'h0000B7C8, 0, 8'hC8};
        vt[2] = '{4'b0100, 32'h003D0000, 2, 8'h3D};
        vt[3] = '{4'b0001, 32'h00000099, 0, 8'h99};
        vt[4] = '{4'b1010, 32'h2600D400, 1, 8'hD4};
        vt[5] = '{4'b1001, 32'hE100000F, 3, 8'hE1};

        RST = 1'b0;
        REQ = '0;
        REQ_DATA = '0;
        repeat (3) @(negedge CLK);
        chk("rst_gnt", {28'd0, GNT}, 32'd0);
        chk("rst_tx_start", {31'd0, TX_START}, 32'd0);
        chk("rst_tx_data", {24'd0, TX_DATA}, 32'hFF);
        chk("rst_active", {31'd0, ACTIVE}, 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 6; i++) begin
            REQ = vt[i].req;
            REQ_DATA = vt[i].data;
            wait_grant(ch);
            chk($sformatf("vec%0d_gnt", i), ch, vt[i].exp_ch);
            REQ = '0;
            REQ_DATA = ~vt[i].data;
            wait_end();
            check_pkt($sformatf("vec%0d", i), vt[i].exp_ch, vt[i].exp_dat);
        end

        REQ = 4'b1111;
        REQ_DATA = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            wait_grant(ch);
            chk("rr_all_gnt", ch, i % 4);
            if (i == 4) REQ = '0;
            wait_end();
            check_pkt("rr_all", i % 4, 8'((i % 4 + 1) * 17));
        end

        s0 = start_cnt;
        REQ = 4'b0100;
        REQ_DATA = 32'h00AB0000;
        wait_grant(ch);
        chk("abort_gnt", ch, 2);
        REQ = '0;
        n = 0;
        while (start_cnt < s0 + 2 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("abort_reached_dat", {31'd0, start_cnt >= s0 + 2}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("abort_gnt_out", {28'd0, GNT}, 32'd0);
        chk("abort_tx_start", {31'd0, TX_START}, 32'd0);
        chk("abort_active", {31'd0, ACTIVE}, 32'd0);
        chk("abort_tx_data", {24'd0, TX_DATA}, 32'hFF);
        tx_log.delete();
        have_done = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        REQ = 4'b1111;
        REQ_DATA = 32'h44332211;
        wait_grant(ch);
        chk("post_reset_gnt", ch, 0);
        REQ = '0;
        wait_end();
        check_pkt("post_reset", 0, 8'h11);

        busy_force = 1'b1;
        REQ = 4'b0010;
        REQ_DATA = 32'h00005A00;
        wait_grant(ch);
        chk("busy_gnt", ch, 1);
        REQ = '0;
        s0 = start_cnt;
        repeat (50) @(negedge CLK);
        chk("busy_hold_start", start_cnt - s0, 32'd0);
        busy_force = 1'b0;
        @(negedge CLK);
        chk("busy_release_start", {31'd0, TX_START}, 32'd1);
        wait_end();
        check_pkt("busy", 1, 8'h5A);

        repeat (GAP + 4) @(negedge CLK);
        done_inj = 1'b1;
        @(negedge CLK);
        done_inj = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (ACTIVE || TX_START || GNT != '0) bad++;
        end
        chk("spurious_done_idle", bad, 32'd0);
        early_arm = 1'b1;
        REQ = 4'b1000;
        REQ_DATA = 32'hC3000000;
        wait_grant(ch);
        chk("late_drop_gnt", ch, 3);
        @(negedge CLK);
        REQ = '0;
        REQ_DATA = '1;
        wait_end();
        check_pkt("late_drop", 3, 8'hC3);

        rr = 0;
        for (int j = 0; j < NCH; j++) pdat[j] = 8'($urandom);
        pend = 4'($urandom_range(1, 15));
        REQ = pend;
        for (int j = 0; j < NCH; j++) REQ_DATA[8*j +: 8] = pdat[j];
        for (int p = 0; p < 24; p++) begin
            exp_ch = -1;
            for (int j = 0; j < NCH; j++)
                if (exp_ch < 0 && pend[(rr + j) % NCH]) exp_ch = (rr + j) % NCH;
            wait_grant(ch);
            chk("rand_gnt", ch, exp_ch);
            if (ch < 0) break;
            gbyte = pdat[exp_ch];
            pend[exp_ch] = 1'b0;
            rr = (exp_ch + 1) % NCH;
            for (int j = 0; j < NCH; j++) begin
                if (!pend[j]) begin
                    pdat[j] = 8'($urandom);
                    if ($urandom_range(0, 2) == 0) pend[j] = 1'b1;
                end
            end
            if (pend == '0) begin
                k = $urandom_range(0, NCH - 1);
                pend[k] = 1'b1;
            end
            REQ = pend;
            for (int j = 0; j < NCH; j++) REQ_DATA[8*j +: 8] = pdat[j];
            wait_end();
            check_pkt("rand", exp_ch, gbyte);
        end
        REQ = '0;

        repeat (5) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
